// File: rtl/phy_crc32_pkg.sv
// Shared constants, state encoding and helpers for the PHY CRC32 generator and checker.
package phy_crc32_pkg;

  localparam logic [31:0] PHY_CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] PHY_CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] PHY_CRC32_RESIDUE = 32'hC704_DD7B;
  localparam int          PHY_CRC32_NIBS    = 8;

  typedef enum logic {
    S_DATA = 1'b0,
    S_CRC  = 1'b1
  } crc_state_e;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/phy_crc32_nib_step.sv
// Combinational CRC32 update for one nibble, bit0 shifted in first (MSB-first register form).
module phy_crc32_nib_step
  import phy_crc32_pkg::*;
#(
  parameter logic [31:0] CRC_POLY = PHY_CRC32_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  logic [31:0] crc_v;
  logic        fb;

  always_comb begin
    crc_v = crc_in;
    fb    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fb    = nib[i] ^ crc_v[31];
      crc_v = {crc_v[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/phy_crc32_tx.sv
// TX-side CRC32 generator: forwards data nibbles with one cycle of latency,
// then appends the complemented, bit-reversed CRC as 8 nibbles, low nibble first.
module phy_crc32_tx
  import phy_crc32_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = PHY_CRC32_INIT,
  parameter logic [31:0] CRC_POLY = PHY_CRC32_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_abort,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [2:0] LAST_CNT = 3'(PHY_CRC32_NIBS - 1);

  crc_state_e  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_tx_q, crc_tx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;

  logic [31:0] crc_step;
  logic        out_free;
  logic        in_fire;

  phy_crc32_nib_step #(
    .CRC_POLY(CRC_POLY)
  ) u_step (
    .crc_in (crc_q),
    .nib    (in_data),
    .crc_out(crc_step)
  );

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_DATA) && !tx_abort && out_free;
  assign in_fire   = in_valid && in_ready;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_DATA) || out_valid_q;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    crc_tx_d    = crc_tx_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (tx_abort) begin
      state_d     = S_DATA;
      crc_d       = CRC_INIT;
      cnt_d       = 3'd0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      // An accepted output empties the register unless something reloads it below.
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      case (state_q)
        S_DATA: begin
          if (in_fire) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            crc_d       = crc_step;
            if (in_last) begin
              state_d  = S_CRC;
              crc_tx_d = ~bit_rev32(crc_step);
              cnt_d    = 3'd0;
            end
          end
        end
        S_CRC: begin
          if (out_free) begin
            out_data_d  = crc_tx_q[{cnt_q, 2'b00} +: 4];
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == LAST_CNT);
            if (cnt_q == LAST_CNT) begin
              state_d = S_DATA;
              crc_d   = CRC_INIT;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DATA;
      crc_q       <= CRC_INIT;
      crc_tx_q    <= 32'h0;
      cnt_q       <= 3'd0;
      out_data_q  <= 4'h0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_tx_q    <= crc_tx_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_phy_crc32_tx.sv
// Directed bench for phy_crc32_tx: golden CRC vectors, stalls, back-to-back, abort, reset, residue loopback.
module tb_phy_crc32_tx;

  localparam logic [31:0] RESIDUE  = 32'hC704_DD7B;
  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] POLY_REF = 32'hEDB8_8320;

  logic       clk;
  logic       rst_n;
  logic       tx_abort;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  int check_count = 0;
  int err_count   = 0;

  logic [3:0] stim_d[$];
  bit         stim_l[$];
  logic [3:0] exp_d[$];
  bit         exp_l[$];
  logic [3:0] cap_d[$];
  bit         cap_l[$];
  int         cap_cyc[$];
  int         acc_cyc[$];

  phy_crc32_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_abort (tx_abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard reflected CRC32 over a nibble stream; an independent reference for the RTL form.
  function automatic logic [31:0] goldenCrc(input logic [3:0] nibs[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (nibs[k]) begin
      for (int b = 0; b < 4; b++) begin
        if (c[0] ^ nibs[k][b]) c = (c >> 1) ^ POLY_REF;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Receive-side checker: register after data plus appended CRC.
  function automatic logic [31:0] rxResidue(input logic [3:0] nibs[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    logic fb;
    foreach (nibs[k]) begin
      for (int b = 0; b < 4; b++) begin
        fb = nibs[k][b] ^ c[31];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  task automatic clearAll();
    stim_d.delete(); stim_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic addNib(input logic [3:0] n, input bit last);
    stim_d.push_back(n); stim_l.push_back(last);
    exp_d.push_back(n);  exp_l.push_back(1'b0);
  endtask

  task automatic addByte(input logic [7:0] b, input bit last);
    addNib(b[3:0], 1'b0);
    addNib(b[7:4], last);
  endtask

  task automatic addCrc(input logic [31:0] c);
    for (int k = 0; k < 8; k++) begin
      exp_d.push_back(c[4*k +: 4]);
      exp_l.push_back(k == 7);
    end
  endtask

  task automatic addString123();
    for (int k = 1; k <= 9; k++) addByte(8'h30 + 8'(k), k == 9);
  endtask

  // kill_kind: 0 none, 1 abort while capture index kill_idx is presented, 2 reset when kill_idx nibbles sent.
  task automatic applyStimulus(input bit stall, input int kill_kind, input int kill_idx, output bit killed);
    int sent = 0, cycles = 0, lasts_seen = 0, n_pk = 0;
    bit in_crc = 0, hold_v = 0, hold_l = 0;
    logic [3:0] hold_d = 4'h0;
    foreach (stim_l[k]) if (stim_l[k]) n_pk++;
    cap_d.delete(); cap_l.delete(); cap_cyc.delete(); acc_cyc.delete();
    killed = 0;
    while (lasts_seen < n_pk && cycles < 4000 && !killed) begin
      @(negedge clk);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = sent < stim_d.size();
      in_data   = in_valid ? stim_d[sent] : 4'h0;
      in_last   = in_valid ? stim_l[sent] : 1'b0;
      #1;
      if (hold_v) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", {out_last, out_data}, {hold_l, hold_d});
      end
      if (out_valid && out_last) in_crc = 0;
      if (in_crc) begin
        checkOutput("crc_in_ready", in_ready, 0);
        checkOutput("crc_busy", busy, 1);
      end
      if (kill_kind == 1 && out_valid && cap_d.size() == kill_idx) begin
        tx_abort = 1'b1;
        #1;
        checkOutput("abort_in_ready", in_ready, 0);
        killed = 1;
      end else if (kill_kind == 2 && sent == kill_idx) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_busy", busy, 0);
        killed = 1;
      end else begin
        if (in_valid && in_ready) begin
          acc_cyc.push_back(cycles);
          if (in_last) in_crc = 1;
          sent++;
        end
        if (out_valid && out_ready) begin
          cap_d.push_back(out_data); cap_l.push_back(out_last); cap_cyc.push_back(cycles);
          if (out_last) lasts_seen++;
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
      end
      cycles++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 4'h0;
    if (!killed && lasts_seen < n_pk) checkOutput("timeout_packets", lasts_seen, n_pk);
  endtask

  task automatic compareCapture(input string tag);
    checkOutput($sformatf("%s_len", tag), cap_d.size(), exp_d.size());
    for (int k = 0; k < cap_d.size() && k < exp_d.size(); k++)
      checkOutput($sformatf("%s_nib%0d", tag, k), {cap_l[k], cap_d[k]}, {exp_l[k], exp_d[k]});
  endtask

  initial begin
    bit killed;
    int bad;
    logic [3:0] pkt[$];
    logic [3:0] rx[$];
    int len;

    rst_n = 1'b0; tx_abort = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 4'h0; out_ready = 1'b1;
    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_last", out_last, 0);

    // Case 1: "123456789" -> 32'hCBF43926, latency 1, full throughput
    clearAll(); addString123(); addCrc(32'hCBF4_3926);
    applyStimulus(1'b0, 0, 0, killed);
    compareCapture("case1");
    bad = 0;
    for (int k = 0; k < 18 && k < acc_cyc.size() && k < cap_cyc.size(); k++)
      if (cap_cyc[k] != acc_cyc[k] + 1) bad++;
    checkOutput("case1_latency_errs", bad, 0);
    bad = 0;
    for (int k = 1; k < cap_cyc.size(); k++)
      if (cap_cyc[k] != cap_cyc[k-1] + 1) bad++;
    checkOutput("case1_gap_errs", bad, 0);

    // Case 2: byte 0x00 twice back to back -> 32'hD202EF8D each
    clearAll();
    addByte(8'h00, 1'b1); addCrc(32'hD202_EF8D);
    addByte(8'h00, 1'b1); addCrc(32'hD202_EF8D);
    applyStimulus(1'b0, 0, 0, killed);
    compareCapture("case2");
    if (cap_cyc.size() > 10 && acc_cyc.size() > 2) begin
      checkOutput("case2_b2b_gap", cap_cyc[10] - cap_cyc[9], 1);
      checkOutput("case2_b2b_accept", acc_cyc[2], cap_cyc[9]);
    end else begin
      checkOutput("case2_b2b_short", cap_cyc.size(), 20);
    end

    // Case 3: case 1 with random output stalls
    clearAll(); addString123(); addCrc(32'hCBF4_3926);
    applyStimulus(1'b1, 0, 0, killed);
    compareCapture("case3");

    // Case 4: random-length packets, golden CRC and residue checker, then a corrupted bit
    for (int p = 0; p < 6; p++) begin
      clearAll(); pkt.delete();
      len = (p == 0) ? 1 : ((p == 1) ? 64 : $urandom_range(1, 64));
      for (int k = 0; k < len; k++) begin
        pkt.push_back(4'($urandom_range(0, 15)));
        addNib(pkt[k], k == len - 1);
      end
      addCrc(goldenCrc(pkt));
      applyStimulus(p[0], 0, 0, killed);
      compareCapture($sformatf("rand%0d", p));
      rx = cap_d;
      checkOutput($sformatf("rand%0d_residue", p), rxResidue(rx), RESIDUE);
      if (rx.size() > 0) rx[0][$urandom_range(0, 3)] ^= 1'b1;
      checkOutput($sformatf("rand%0d_flip_detect", p), rxResidue(rx) == RESIDUE, 0);
    end

    // Case 5: abort on CRC nibble 3 of case 2, then resend case 2
    clearAll(); addByte(8'h00, 1'b1); addCrc(32'hD202_EF8D);
    applyStimulus(1'b0, 1, 5, killed);
    checkOutput("abort_taken", killed, 1);
    @(negedge clk);
    tx_abort = 1'b0;
    #1;
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_out_last", out_last, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    applyStimulus(1'b0, 0, 0, killed);
    compareCapture("case5");

    // Case 6: reset mid-data, then case 1 again
    clearAll(); addString123(); addCrc(32'hCBF4_3926);
    applyStimulus(1'b0, 2, 7, killed);
    checkOutput("reset_taken", killed, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rerst_in_ready", in_ready, 1);
    applyStimulus(1'b0, 0, 0, killed);
    compareCapture("case6");

    $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
    $finish;
  end

endmodule
